mem_port_arbiter: RTL

- Shares the single unified 256 x 32 memory port between two requesters: instruction fetch (IF) and data load/store (DM).
- Sits between the CPU core and the memory array.
- The memory is read combinationally and written on the clock edge.
- The arbiter registers read data, so every read returns one cycle after its grant.
- DM has fixed priority, with a starvation guard that forces an IF grant after a bounded wait.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_arb_starve_fsm.sv | 38 +++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DEPTH  = 256;

    typedef enum logic {
        PRIO_DM = 1'b0,
        PRIO_IF = 1'b1
    } prio_state_e;

endpackage

// File: rtl/mem_arb_starve_fsm.sv
// Starvation guard: counts consecutive denied IF cycles and hands priority to IF
// for exactly one grant once the count reaches STARVE_LIMIT.
module mem_arb_starve_fsm
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    prio_state_e state;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            state      <= PRIO_DM;
        end else if (!if_req || if_gnt) begin
            // A grant or a dropped request both end the starvation episode.
            starve_cnt <= '0;
            state      <= PRIO_DM;
        end else if (starve_cnt >= LIMIT - 4'd1) begin
            starve_cnt <= LIMIT;
            state      <= PRIO_IF;
        end else begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign force_if = (state == PRIO_IF);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (IF / DM) for a single 256x32 memory port.
// Optional conflict counter enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = MEM_ADDR_W,
    parameter int unsigned DATA_W       = WORD_SIZE,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       conflict_cnt
`endif
);

    logic force_if;
    logic if_rvalid_q;
    logic dm_rvalid_q;

    mem_arb_starve_fsm #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_fsm (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .force_if(force_if)
    );

    always_comb begin
        if_gnt    = !rst && if_req && (!dm_req || force_if);
        dm_gnt    = !rst && dm_req && !if_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
        end else begin
            if_rvalid_q <= if_gnt;
            dm_rvalid_q <= dm_gnt && !dm_we;
            if (if_gnt) begin
                if_rdata <= mem_rdata;
            end
            if (dm_gnt && !dm_we) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    // Masking with rst cancels a read whose grant was in flight when reset rose.
    assign if_rvalid = if_rvalid_q && !rst;
    assign dm_rvalid = dm_rvalid_q && !rst;

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (if_req && dm_req && conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
